dfd_accumulator_space_arbiter: RTL and testbench

- Shares the trace accumulator's packet-space request/grant handshake between NUM_REQUESTERS packet generators.
- Uses round-robin arbitration and holds one request until the accumulator grants space.
- Sequences accumulator flushes: blocks new arbitration except from a flush owner (which pads partial banks) until the accumulator reports empty or a timeout expires.
- Sits between the packet generators and the accumulator's space-request port; the winner index steers the cross-connect data mux.

---
 rtl/dfd_packetizer_pkg.sv | 28 ++
 rtl/dfd_accumulator_space_arbiter_if.sv | 40 ++++
 rtl/dfd_rr_arbiter.sv | 28 ++
 rtl/dfd_accumulator_space_arbiter.sv | 137 +++++++++++++
 tb/tb_dfd_accumulator_space_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dfd_packetizer_pkg.sv
// Shared packetizer types and helpers: arbiter state encoding and the
// cyclic first-set-bit search used by round-robin arbiters.
`default_nettype none

package dfd_packetizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Zero bits above the real requester count never match, so a 32-wide
  // cyclic search is equivalent to searching modulo the requester count.
  function automatic logic [4:0] rr_pick(input logic [31:0] mask, input logic [4:0] ptr);
    logic [4:0] idx;
    logic [4:0] pick;
    pick = ptr;
    for (int i = 31; i >= 0; i--) begin
      idx = ptr + 5'(i);
      if (mask[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dfd_accumulator_space_arbiter_if.sv
// Space-request bundle between the packet generators, the accumulator
// and the space arbiter.
`default_nettype none

interface dfd_accumulator_space_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int SW             = 7
);
  localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [NUM_REQUESTERS-1:0]    req_valid;
  logic [NUM_REQUESTERS*SW-1:0] req_space_in_bytes;
  logic [NUM_REQUESTERS-1:0]    req_grant;
  logic [IW-1:0]                req_sel;
  logic [SW-1:0]                request_packet_space_in_bytes_with_frame_support;
  logic                         requested_packet_space_granted;
  logic                         flush_req;
  logic                         accumulator_empty;
  logic                         flush_done;
  logic                         flush_timeout;
  logic                         size_error;
  logic                         busy;

  modport master (
    output req_valid, req_space_in_bytes, requested_packet_space_granted,
           flush_req, accumulator_empty,
    input  req_grant, req_sel, request_packet_space_in_bytes_with_frame_support,
           flush_done, flush_timeout, size_error, busy
  );

  modport slave (
    input  req_valid, req_space_in_bytes, requested_packet_space_granted,
           flush_req, accumulator_empty,
    output req_grant, req_sel, request_packet_space_in_bytes_with_frame_support,
           flush_done, flush_timeout, size_error, busy
  );

endinterface

`default_nettype wire

// File: rtl/dfd_rr_arbiter.sv
// Combinational round-robin pick: first set mask bit at or after the
// pointer, cyclically, as both a one-hot vector and an index.
`default_nettype none

module dfd_rr_arbiter
  import dfd_packetizer_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic [NUM_REQUESTERS-1:0]                                  mask_i,
  input  logic [((NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1)-1:0] ptr_i,
  output logic [NUM_REQUESTERS-1:0]                                  grant_o,
  output logic [((NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1)-1:0] idx_o
);
  localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [31:0] mask_ext;

  always_comb begin
    mask_ext                       = '0;
    mask_ext[NUM_REQUESTERS-1:0]   = mask_i;
    idx_o                          = IW'(rr_pick(mask_ext, 5'(ptr_i)));
    grant_o                        = (|mask_i) ? (NUM_REQUESTERS'(1) << idx_o) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/dfd_accumulator_space_arbiter.sv
// Round-robin arbiter for the trace accumulator's space request port,
// with flush sequencing that only lets the flush owner through while draining.
`default_nettype none

module dfd_accumulator_space_arbiter
  import dfd_packetizer_pkg::*;
#(
  parameter int NUM_REQUESTERS                  = 4,
  parameter int ACCUMULATOR_DATA_WIDTH_IN_BYTES = 64,
  parameter int FLUSH_OWNER                     = 0,
  parameter int FLUSH_TIMEOUT_CYCLES            = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  dfd_accumulator_space_arbiter_if.slave bus
);
  localparam int SW = $clog2(ACCUMULATOR_DATA_WIDTH_IN_BYTES) + 1;
  localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CW = $clog2(FLUSH_TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] OWNER_IDX = IW'(FLUSH_OWNER);

  arb_state_t              state_q, state_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]           winner_q, winner_d;
  logic                    flush_pending_q, flush_pending_d;
  logic [CW-1:0]           drain_cnt_q, drain_cnt_d;

  logic [SW-1:0]           size_w [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] size_ok;
  logic [NUM_REQUESTERS-1:0] elig;
  logic [NUM_REQUESTERS-1:0] arb_onehot;
  logic [IW-1:0]           arb_idx;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [SW-1:0]           req_size;
  logic                    done;
  logic                    timeout;
  logic                    owner_grant;

  always_comb begin
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      size_w[k]  = bus.req_space_in_bytes[k*SW +: SW];
      size_ok[k] = (size_w[k] != '0) && (size_w[k] <= SW'(ACCUMULATOR_DATA_WIDTH_IN_BYTES));
    end
    elig = bus.req_valid & size_ok;
  end

  dfd_rr_arbiter #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_rr (
    .mask_i  (elig),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_onehot),
    .idx_o   (arb_idx)
  );

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    winner_d        = winner_q;
    flush_pending_d = flush_pending_q | (bus.flush_req && (state_q != DRAIN));
    drain_cnt_d     = drain_cnt_q;
    grant           = '0;
    req_size        = '0;
    done            = 1'b0;
    timeout         = 1'b0;
    owner_grant     = elig[FLUSH_OWNER] && bus.requested_packet_space_granted;

    case (state_q)
      IDLE: begin
        if (flush_pending_q) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
          winner_d    = OWNER_IDX;
        end else if (|arb_onehot) begin
          winner_d = arb_idx;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        req_size = size_w[winner_q];
        if (bus.requested_packet_space_granted) begin
          grant[winner_q] = 1'b1;
          rr_ptr_d        = (winner_q == IW'(NUM_REQUESTERS - 1)) ? '0 : winner_q + IW'(1);
          state_d         = IDLE;
        end else if (!bus.req_valid[winner_q]) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + CW'(1);
        if (elig[FLUSH_OWNER]) begin
          req_size           = size_w[FLUSH_OWNER];
          grant[FLUSH_OWNER] = bus.requested_packet_space_granted;
        end
        // A padding grant this cycle means the accumulator is about to refill.
        if (bus.accumulator_empty && !owner_grant) begin
          done            = 1'b1;
          flush_pending_d = 1'b0;
          drain_cnt_d     = '0;
          state_d         = IDLE;
        end else if (drain_cnt_q == CW'(FLUSH_TIMEOUT_CYCLES - 1)) begin
          done            = 1'b1;
          timeout         = 1'b1;
          flush_pending_d = 1'b0;
          drain_cnt_d     = '0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      winner_q        <= '0;
      flush_pending_q <= 1'b0;
      drain_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      winner_q        <= winner_d;
      flush_pending_q <= flush_pending_d;
      drain_cnt_q     <= drain_cnt_d;
    end
  end

  assign bus.req_grant     = grant;
  assign bus.req_sel       = winner_q;
  assign bus.request_packet_space_in_bytes_with_frame_support = req_size;
  assign bus.flush_done    = done;
  assign bus.flush_timeout = timeout;
  assign bus.size_error    = |(bus.req_valid & ~size_ok);
  assign bus.busy          = (state_q != IDLE) || flush_pending_q;

endmodule

`default_nettype wire

// File: tb/tb_dfd_accumulator_space_arbiter.sv
// Directed bench for the accumulator space arbiter; expected values are
// hand-derived per cycle.
`default_nettype none

module tb_dfd_accumulator_space_arbiter;
  localparam int N  = 4;
  localparam int SW = 7;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  dfd_accumulator_space_arbiter_if #(.NUM_REQUESTERS(N), .SW(SW)) bus ();

  dfd_accumulator_space_arbiter #(
    .NUM_REQUESTERS                  (N),
    .ACCUMULATOR_DATA_WIDTH_IN_BYTES (64),
    .FLUSH_OWNER                     (0),
    .FLUSH_TIMEOUT_CYCLES            (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input int s);
    bus.req_valid[k]                  = v;
    bus.req_space_in_bytes[k*SW +: SW] = SW'(s);
  endtask

  task automatic clear_reqs();
    bus.req_valid          = '0;
    bus.req_space_in_bytes = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    clear_reqs();
    bus.requested_packet_space_granted = 1'b0;
    bus.flush_req         = 1'b0;
    bus.accumulator_empty = 1'b0;

    repeat (2) cyc();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_gnt",  32'(bus.req_grant), 0);
    chk("rst_sel",  32'(bus.req_sel), 0);
    chk("rst_out",  32'(bus.request_packet_space_in_bytes_with_frame_support), 0);
    chk("rst_done", 32'(bus.flush_done), 0);
    chk("rst_tmo",  32'(bus.flush_timeout), 0);

    // Two requesters, immediate grant.
    reset = 1'b0;
    set_req(1, 1'b1, 8);
    set_req(2, 1'b1, 16);
    bus.requested_packet_space_granted = 1'b1;
    #4;
    chk("t1_idle_out", 32'(bus.request_packet_space_in_bytes_with_frame_support), 0);
    chk("t1_idle_gnt", 32'(bus.req_grant), 0);
    cyc(); #4;
    chk("t1_sel1", 32'(bus.req_sel), 1);
    chk("t1_out8", 32'(bus.request_packet_space_in_bytes_with_frame_support), 8);
    chk("t1_gnt1", 32'(bus.req_grant), 32'b0010);
    chk("t1_busy", 32'(bus.busy), 1);
    cyc(); #4;
    chk("t1_gap_gnt", 32'(bus.req_grant), 0);
    cyc(); #4;
    chk("t1_out16", 32'(bus.request_packet_space_in_bytes_with_frame_support), 16);
    chk("t1_gnt2", 32'(bus.req_grant), 32'b0100);
    cyc();
    clear_reqs();
    set_req(0, 1'b1, 4);
    set_req(3, 1'b1, 5);
    #4;
    cyc(); #4;
    chk("t1_ptr3_sel", 32'(bus.req_sel), 3);
    chk("t1_ptr3_gnt", 32'(bus.req_grant), 32'b1000);

    // All four valid: rotation 0,1,2,3,0.
    cyc();
    set_req(0, 1'b1, 10);
    set_req(1, 1'b1, 20);
    set_req(2, 1'b1, 30);
    set_req(3, 1'b1, 40);
    #4;
    chk("t2_idle_gnt", 32'(bus.req_grant), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(); #4;
      chk("t2_rot_gnt", 32'(bus.req_grant), 32'(1) << (i % 4));
      chk("t2_rot_out", 32'(bus.request_packet_space_in_bytes_with_frame_support), 10 * ((i % 4) + 1));
      cyc();
      if (i == 4) clear_reqs();
      #4;
      chk("t2_gap_gnt", 32'(bus.req_grant), 0);
    end

    // Illegal sizes are masked.
    cyc();
    set_req(2, 1'b1, 0);
    set_req(3, 1'b1, 65);
    #4;
    chk("t3_szerr", 32'(bus.size_error), 1);
    chk("t3_gnt", 32'(bus.req_grant), 0);
    cyc(); #4;
    chk("t3_busy", 32'(bus.busy), 0);
    chk("t3_out", 32'(bus.request_packet_space_in_bytes_with_frame_support), 0);
    chk("t3_szerr2", 32'(bus.size_error), 1);
    cyc(); clear_reqs(); #4;
    chk("t3_szerr_clr", 32'(bus.size_error), 0);

    // Grant withheld 5 cycles (rr_ptr = 1).
    cyc();
    set_req(1, 1'b1, 8);
    bus.requested_packet_space_granted = 1'b0;
    #4;
    for (int i = 0; i < 5; i++) begin
      cyc(); #4;
      chk("t4_hold_out", 32'(bus.request_packet_space_in_bytes_with_frame_support), 8);
      chk("t4_hold_gnt", 32'(bus.req_grant), 0);
    end
    cyc();
    bus.requested_packet_space_granted = 1'b1;
    #4;
    chk("t4_gnt", 32'(bus.req_grant), 32'b0010);
    cyc();
    clear_reqs();
    bus.requested_packet_space_granted = 1'b0;
    #4;
    chk("t4_after_gnt", 32'(bus.req_grant), 0);
    chk("t4_after_busy", 32'(bus.busy), 0);

    // Abandoned HOLD leaves rr_ptr at 2.
    cyc(); set_req(3, 1'b1, 9); #4;
    cyc(); #4;
    chk("ab_sel3", 32'(bus.req_sel), 3);
    cyc(); clear_reqs(); #4;
    chk("ab_drop_gnt", 32'(bus.req_grant), 0);
    cyc();
    set_req(0, 1'b1, 3);
    set_req(3, 1'b1, 9);
    #4;
    chk("ab_idle_busy", 32'(bus.busy), 0);
    cyc(); #4;
    chk("ab_ptr_kept", 32'(bus.req_sel), 3);
    cyc(); clear_reqs(); #4;
    cyc(); #4;
    chk("ab_end_busy", 32'(bus.busy), 0);

    // Flush during HOLD of requester 1.
    cyc(); set_req(1, 1'b1, 8); #4;
    cyc(); bus.flush_req = 1'b1; #4;
    chk("t5_hold_sel", 32'(bus.req_sel), 1);
    chk("t5_hold_out", 32'(bus.request_packet_space_in_bytes_with_frame_support), 8);
    cyc();
    bus.flush_req = 1'b0;
    bus.requested_packet_space_granted = 1'b1;
    #4;
    chk("t5_gnt1", 32'(bus.req_grant), 32'b0010);
    cyc();
    clear_reqs();
    set_req(0, 1'b1, 12);
    set_req(3, 1'b1, 20);
    #4;
    chk("t5_pend_busy", 32'(bus.busy), 1);
    chk("t5_pend_gnt", 32'(bus.req_grant), 0);
    cyc(); bus.accumulator_empty = 1'b1; #4;
    chk("t5_drain_out", 32'(bus.request_packet_space_in_bytes_with_frame_support), 12);
    chk("t5_drain_gnt", 32'(bus.req_grant), 32'b0001);
    chk("t5_drain_sel", 32'(bus.req_sel), 0);
    chk("t5_grant_wins", 32'(bus.flush_done), 0);
    cyc(); set_req(0, 1'b0, 0); #4;
    chk("t5_done", 32'(bus.flush_done), 1);
    chk("t5_tmo", 32'(bus.flush_timeout), 0);
    chk("t5_blocked", 32'(bus.req_grant), 0);
    cyc(); bus.accumulator_empty = 1'b0; #4;
    chk("t5_done_clr", 32'(bus.flush_done), 0);
    chk("t5_idle_busy", 32'(bus.busy), 0);
    cyc(); #4;
    chk("t5_resume_gnt", 32'(bus.req_grant), 32'b1000);
    cyc();
    clear_reqs();
    bus.requested_packet_space_granted = 1'b0;
    #4;

    // Timeout drain, with a flush_req inside DRAIN that must be ignored.
    cyc(); bus.flush_req = 1'b1; #4;
    cyc(); bus.flush_req = 1'b0; #4;
    chk("t6_pend_busy", 32'(bus.busy), 1);
    for (int d = 1; d <= 8; d++) begin
      cyc();
      bus.flush_req = (d == 3);
      #4;
      chk("t6_done", 32'(bus.flush_done), (d == 8) ? 1 : 0);
      chk("t6_tmo", 32'(bus.flush_timeout), (d == 8) ? 1 : 0);
    end
    cyc();
    bus.flush_req = 1'b0;
    set_req(0, 1'b1, 7);
    bus.requested_packet_space_granted = 1'b1;
    #4;
    chk("t6_after_busy", 32'(bus.busy), 0);
    chk("t6_after_done", 32'(bus.flush_done), 0);
    cyc(); #4;
    chk("t6_arb_gnt", 32'(bus.req_grant), 32'b0001);
    chk("t6_arb_out", 32'(bus.request_packet_space_in_bytes_with_frame_support), 7);
    cyc();
    clear_reqs();
    bus.requested_packet_space_granted = 1'b0;
    #4;

    // Reset in the middle of DRAIN.
    cyc(); bus.flush_req = 1'b1; #4;
    cyc(); bus.flush_req = 1'b0; #4;
    cyc(); #4;
    cyc(); #4;
    chk("t7_drain_busy", 32'(bus.busy), 1);
    #1 reset = 1'b1;
    #1;
    chk("t7_rst_busy", 32'(bus.busy), 0);
    chk("t7_rst_done", 32'(bus.flush_done), 0);
    chk("t7_rst_tmo", 32'(bus.flush_timeout), 0);
    cyc();
    reset = 1'b0;
    #4;
    chk("t7_post_busy", 32'(bus.busy), 0);
    cyc(); #4;
    chk("t7_post_done", 32'(bus.flush_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
